// File: rtl/period_meter.sv
// Measures the period and high time of a slow, asynchronous square wave in clk
// cycles. Single-shot by default; CONTINUOUS=1 re-arms on every closing edge.
module period_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter bit CONTINUOUS  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAX = '1;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig_s, sig_d, rise;
  logic [CNT_W-1:0]       cnt, hcnt;
  logic                   sat;

  assign sig_s = sync_q[SYNC_STAGES-1];
  assign rise  = sig_s & ~sig_d;
  assign busy  = (state != IDLE);
  // Saturation only wins when no edge arrives in the same cycle.
  assign sat   = (state == MEAS) && !rise && (cnt == MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      sig_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      sig_d  <= sig_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = ARM;
      ARM:  if (rise)  state_n = MEAS;
      MEAS: begin
        if (sat)                      state_n = IDLE;
        else if (rise && !CONTINUOUS) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      hcnt      <= '0;
      valid     <= 1'b0;
      period    <= '0;
      high_time <= '0;
      overflow  <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        ARM: begin
          if (rise) begin
            cnt  <= ONE;
            hcnt <= ONE;
          end
        end
        MEAS: begin
          if (rise) begin
            period    <= cnt;
            high_time <= hcnt;
            overflow  <= 1'b0;
            valid     <= 1'b1;
            cnt       <= ONE;
            hcnt      <= ONE;
          end else if (cnt == MAX) begin
            period    <= MAX;
            high_time <= hcnt;
            overflow  <= 1'b1;
            valid     <= 1'b1;
          end else begin
            cnt  <= cnt + ONE;
            hcnt <= hcnt + CNT_W'(sig_s);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures an externally generated slow square wave in `clk` cycles: full period and high time.
- Inverse of the team's clock divider. The divider turns `clk` into slow taps; this block takes such a slow signal (or any asynchronous slow input) and reports how many `clk` cycles one period spans.
- Used to self-check divider taps on the board and to measure external slow inputs.
- Single-shot by default; optional continuous re-arm.

Parameters:
- CNT_W, 16, width of the period and high-time counters and outputs.
- SYNC_STAGES, 2, number of synchroniser flops on `sig_in` (legal values 2..4).
- CONTINUOUS, 0, 1 means the edge that closes a measurement also opens the next one.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- sig_in  input  1  slow signal under test; asynchronous to `clk`.
- start  input  1  one-cycle request to arm a measurement.
- busy  output  1  high in ARM or MEAS.
- valid  output  1  one-cycle pulse when `period`/`high_time`/`overflow` are updated.
- period  output  CNT_W  clk cycles from one rising edge to the next.
- high_time  output  CNT_W  clk cycles `sig_in` was high within that period.
- overflow  output  1  result was truncated because the counter saturated.

Behaviour:
- Synchroniser and edge detect:
  - `sig_in` passes through SYNC_STAGES flops, giving `sig_s`, then one more flop, giving `sig_d`.
  - `rise = sig_s & ~sig_d` (combinational).
  - Synchroniser and edge flops reset to 0.
- Reset values: state = IDLE; `busy`=0, `valid`=0, `period`=0, `high_time`=0, `overflow`=0; internal counters = 0.
- States: IDLE, ARM, MEAS.
- IDLE:
  - `start`=1 → ARM.
  - `start` in any other state is ignored.
- ARM:
  - Waits indefinitely for `rise`.
  - On `rise`: `cnt`<=1, `hcnt`<=1, go to MEAS.
- MEAS, each cycle without `rise`:
  - `cnt`<=`cnt`+1.
  - `hcnt`<=`hcnt`+`sig_s`.
- MEAS, on `rise`:
  - Register `period`<=`cnt` and `high_time`<=`hcnt`, `overflow`<=0, `valid`<=1.
  - If CONTINUOUS=0: go to IDLE.
  - If CONTINUOUS=1: `cnt`<=1, `hcnt`<=1, stay in MEAS.
- MEAS, saturation (checked before `rise`):
  - If `cnt`=all-ones and no `rise` this cycle: `period`<=all-ones, `high_time`<=`hcnt`, `overflow`<=1, `valid`<=1, go to IDLE. This applies regardless of CONTINUOUS.
  - `hcnt` never exceeds `cnt`, so it needs no separate saturation.
- Result timing:
  - `valid` and the new result become visible on the clock edge that samples the closing `rise`.
  - `valid` is low on every other cycle.
  - Outputs hold their last values until the next `valid`.
- Latency: a `sig_in` rising transition appears as `rise` SYNC_STAGES (±1) cycles later. Both ends of a period see the same delay, so `period` is exact for a stable input.
- `busy`: high exactly while the state is ARM or MEAS. It falls in the same cycle that `valid` rises, except in continuous mode.
- Simultaneous events:
  - `start` in the same cycle as a `rise` while IDLE → go to ARM only; that `rise` is not used.
  - `rst` overrides everything: a measurement in progress is discarded and no `valid` is issued.
  - `rst` mid-MEAS clears `period`, `high_time` and `overflow` to 0.
- Width rule: the minimum measurable period is 2 cycles. A glitch shorter than one `clk` may be lost; this is acceptable.

Test Plan:
- Divider tap: `sig_in` = bit 3 of a free-running `clk` counter (period 16, high 8); `start` → `valid` on the second sampled rise with `period`=16, `high_time`=8, `overflow`=0, then IDLE with `busy`=0.
- Duty cycle: `sig_in` high 3 / low 7 cycles; `start` → `period`=10, `high_time`=3; a repeated `start` gives the identical result.
- Overflow: CNT_W=8, `sig_in` with period 300; `start` → after the first rise `valid` fires with `period`=255, `overflow`=1, `high_time`≤255, state IDLE.
- Continuous: CONTINUOUS=1, period 16 input → `valid` every 16 cycles with `period`=16 each time and `busy` stuck at 1; input switched to period 32 → the next complete result reads 32.
- Reset mid-measurement: `rst` pulsed 5 cycles into MEAS → no `valid`; `period`/`high_time`/`overflow`=0; `busy`=0; a later `start` measures correctly.
- Start ignored and no edge: `start` pulsed during MEAS → result unchanged (16/8); `sig_in` held constant after `start` → `busy` stays 1 and `valid` never fires until `rst`.
